jtkcpu_divctl: RTL and testbench

Sequencer-side controller for the KONAMI-1 DIV/DIVS instructions, upstream of `jtkcpu_div`. Accepts a divide request from the instruction sequencer, latches operands, drives the divider's edge-triggered start, waits for completion, then presents the quotient/remainder write-back and N/Z/V/C flags. It owns the start/busy handshake so the sequencer sees one `req` in and one `done` pulse out.

---
 rtl/jtkcpu_divctl.sv | 189 ++++++++++++++++++
 tb/tb_jtkcpu_divctl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_divctl.sv
// -----------------------------------------------------------------------------
// jtkcpu_divctl
//
// Sequencer-side controller for the KONAMI-1 DIV/DIVS instructions. Sits in
// front of jtkcpu_div: takes one request from the instruction sequencer,
// latches the operands, produces the divider's edge-triggered start level,
// waits for the divider to finish and presents the write-back values and the
// N/Z/V/C flags together with a single-period done strobe.
//
// Optional feature (compile-time macro JTKCPU_DIV0_TRAP_EN):
//   defined   : a zero divisor never reaches the divider; the request finishes
//               one cen period after it is sampled with x_out=dividend, b_out=0,
//               flags={N0,Z0,V1,C0} and div0 high while done is high.
//   undefined : a zero divisor is issued like any other; div0 is tied low.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   cen           clock enable; every register advances only when cen=1
//   req           divide request, sampled in IDLE only
//   sign, len     signed divide / 1:16-by-8, 0:8-by-8
//   dividend      operand X (8-bit mode uses [7:0])
//   divisor       operand B
//   div_start     start level towards the divider (high in ISSUE)
//   div_op0/1     latched dividend / divisor
//   div_len/sign  latched mode bits
//   div_busy      divider busy
//   div_quot/rem  divider quotient / remainder
//   div_v         divider overflow
//   busy          high whenever the controller is not idle
//   done          result-valid strobe, one cen period
//   x_out, b_out  quotient for X, remainder for B
//   flags         {N,Z,V,C}
//   div0          divide-by-zero trap indication
// -----------------------------------------------------------------------------
module jtkcpu_divctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        req,
  input  logic        sign,
  input  logic        len,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        div_start,
  output logic [15:0] div_op0,
  output logic [7:0]  div_op1,
  output logic        div_len,
  output logic        div_sign,
  input  logic        div_busy,
  input  logic [15:0] div_quot,
  input  logic [7:0]  div_rem,
  input  logic        div_v,
  output logic        busy,
  output logic        done,
  output logic [15:0] x_out,
  output logic [7:0]  b_out,
  output logic [3:0]  flags,
  output logic        div0
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ARM,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t state, state_nx;

  // High when the request in flight is a zero-divisor trap.
  logic trap;

`ifdef JTKCPU_DIV0_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if (cen && state == ST_IDLE && req) begin
      trap_q <= (divisor == 8'd0);
    end
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments so every register
  // sampled on this edge sees the pre-edge value, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (cen) begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (req) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        // A trapped request spends this period here without raising start,
        // so the divider never sees an edge and done follows one period later.
        div_start = !trap;
        state_nx  = trap ? ST_DONE : ST_ARM;
      end
      ST_ARM: begin
        // The divider raises busy on this same edge, so busy is not looked at.
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!div_busy) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign div0 = (state == ST_DONE) && trap;

  // ---------------------------------------------------------------------------
  // Flag derivation from the divider result
  // ---------------------------------------------------------------------------
  // N/Z look at the width of the operation that is in flight, not at the
  // current len input, which the sequencer may already have changed.
  logic res_n, res_z, res_c;

  assign res_n = div_len ? div_quot[15] : div_quot[7];
  assign res_z = div_len ? (div_quot == 16'd0) : (div_quot[7:0] == 8'd0);
  assign res_c = (div_rem != 8'd0);

  // ---------------------------------------------------------------------------
  // Operand latches and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div_op0  <= '0;
      div_op1  <= '0;
      div_len  <= 1'b0;
      div_sign <= 1'b0;
      x_out    <= '0;
      b_out    <= '0;
      flags    <= '0;
    end else if (cen) begin
      if (state == ST_IDLE && req) begin
        div_op0  <= dividend;
        div_op1  <= divisor;
        div_len  <= len;
        div_sign <= sign;
      end
      if (state == ST_WAIT && !div_busy) begin
        x_out <= div_quot;
        b_out <= div_rem;
        flags <= {res_n, res_z, div_v, res_c};
      end
`ifdef JTKCPU_DIV0_TRAP_EN
      if (state == ST_ISSUE && trap) begin
        x_out <= div_op0;
        b_out <= '0;
        flags <= 4'b0010;
      end
`endif
    end
  end

endmodule

// File: tb/tb_jtkcpu_divctl.sv
// -----------------------------------------------------------------------------
// tb_jtkcpu_divctl
//
// Table-driven bench for jtkcpu_divctl. A behavioural stand-in for jtkcpu_div
// answers the start edge with a busy window of the documented length and a
// quotient/remainder computed from the latched operands. Expected results in
// the vector table are hand-computed. Build with +define+JTKCPU_DIV0_TRAP_EN to
// exercise the trap configuration; the divide-by-zero vector adapts.
// -----------------------------------------------------------------------------
module tb_jtkcpu_divctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        req;
  logic        sign;
  logic        len;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        div_start;
  logic [15:0] div_op0;
  logic [7:0]  div_op1;
  logic        div_len;
  logic        div_sign;
  logic        div_busy;
  logic [15:0] div_quot;
  logic [7:0]  div_rem;
  logic        div_v;
  logic        busy;
  logic        done;
  logic [15:0] x_out;
  logic [7:0]  b_out;
  logic [3:0]  flags;
  logic        div0;

  always #5 clk = ~clk;

  jtkcpu_divctl dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .req       (req),
    .sign      (sign),
    .len       (len),
    .dividend  (dividend),
    .divisor   (divisor),
    .div_start (div_start),
    .div_op0   (div_op0),
    .div_op1   (div_op1),
    .div_len   (div_len),
    .div_sign  (div_sign),
    .div_busy  (div_busy),
    .div_quot  (div_quot),
    .div_rem   (div_rem),
    .div_v     (div_v),
    .busy      (busy),
    .done      (done),
    .x_out     (x_out),
    .b_out     (b_out),
    .flags     (flags),
    .div0      (div0)
  );

  // ---------------------------------------------------------------------------
  // Divider stand-in
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        v;
  } res_t;

  function automatic res_t model_div(input logic [15:0] a, input logic [7:0] b,
                                     input logic s, input logic l);
    int   n, d, q, r;
    res_t res;
    if (l) begin
      if (s) n = $signed(a); else n = int'(a);
    end else begin
      if (s) n = $signed(a[7:0]); else n = int'(a[7:0]);
    end
    if (s) d = $signed(b); else d = int'(b);
    if (d == 0) begin
      res.q = 16'hFFFF;
      res.r = a[7:0];
      res.v = 1'b1;
      return res;
    end
    q = n / d;
    r = n % d;
    res.r = r[7:0];
    if (l) begin
      res.q = q[15:0];
      res.v = s ? (q > 32767 || q < -32768) : (q > 65535);
    end else begin
      res.q = s ? {{8{q[7]}}, q[7:0]} : {8'h00, q[7:0]};
      res.v = s ? (q > 127 || q < -128) : (q > 255);
    end
    return res;
  endfunction

  logic m_busy = 1'b0;
  logic m_prev = 1'b0;
  int   m_cnt  = 0;
  res_t m_res  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_prev <= 1'b0;
      m_cnt  <= 0;
    end else if (cen) begin
      m_prev <= div_start;
      if (div_start && !m_prev) begin
        m_busy <= 1'b1;
        m_cnt  <= div_len ? 16 : 8;
        m_res  <= model_div(div_op0, div_op1, div_sign, div_len);
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_busy <= 1'b0;
      end
    end
  end

  assign div_busy = m_busy;
  assign div_quot = m_res.q;
  assign div_rem  = m_res.r;
  assign div_v    = m_res.v;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Stream monitor for the gated back-to-back run; samples on the falling edge
  // the values the next rising edge will act on.
  logic mon_en     = 1'b0;
  int   runs       = 0;
  int   dones      = 0;
  int   starts     = 0;
  int   gap        = 0;
  int   gap_bad    = 0;
  int   bad_res    = 0;
  logic seen_start = 1'b0;

  always @(negedge clk) begin
    if (mon_en && cen && !rst) begin
      if (!busy && req) runs <= runs + 1;
      if (done) begin
        dones <= dones + 1;
        if (x_out !== 16'd142 || b_out !== 8'd6 || flags !== 4'b0001) bad_res <= bad_res + 1;
      end
      if (div_start) begin
        starts <= starts + 1;
        if (seen_start && gap < 2) gap_bad <= gap_bad + 1;
        seen_start <= 1'b1;
        gap        <= 0;
      end else begin
        gap <= gap + 1;
      end
    end
  end

  typedef struct {
    logic        sign;
    logic        len;
    logic [15:0] x;
    logic [7:0]  b;
    logic [15:0] exp_x;
    logic [7:0]  exp_b;
    logic [3:0]  exp_f;
    int          exp_lat;
    logic        exp_div0;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  // Issue one request with cen=1 and check latency, latches and results.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int nstart;
    logic got;
    @(negedge clk);
    sign     = v.sign;
    len      = v.len;
    dividend = v.x;
    divisor  = v.b;
    cen      = 1'b1;
    req      = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    check($sformatf("v%0d_op0", idx), 32'(div_op0), 32'(v.x));
    check($sformatf("v%0d_op1", idx), 32'(div_op1), 32'(v.b));
    check($sformatf("v%0d_mode", idx), 32'({div_sign, div_len}), 32'({v.sign, v.len}));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    nstart = 0;
    cyc    = 0;
    got    = 1'b0;
    while (!got && cyc < 40) begin
      if (div_start) nstart++;
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1'b1;
    end
    check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_lat));
    check($sformatf("v%0d_start_cnt", idx), 32'(nstart), v.exp_div0 ? 32'd0 : 32'd1);
    check($sformatf("v%0d_x_out", idx), 32'(x_out), 32'(v.exp_x));
    check($sformatf("v%0d_b_out", idx), 32'(b_out), 32'(v.exp_b));
    check($sformatf("v%0d_flags", idx), 32'(flags), 32'(v.exp_f));
    check($sformatf("v%0d_div0", idx), 32'(div0), 32'(v.exp_div0));
    @(posedge clk);
    #1;
    check($sformatf("v%0d_done_low", idx), 32'({done, busy, div0}), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    //               sign  len   X         B      exp_x     exp_b  flags    lat div0
    vecs[0] = '{1'b0, 1'b1, 16'd1000, 8'd7,  16'h008E, 8'h06, 4'b0001, 18, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'hFF9C, 8'h07, 16'hFFF2, 8'hFE, 4'b1001, 18, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h0040, 8'h08, 16'h0008, 8'h00, 4'b0000, 10, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'hABF0, 8'h04, 16'hFFFC, 8'h00, 4'b1000, 10, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'd5,    8'd9,  16'h0000, 8'h05, 4'b0101, 18, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'h1203, 8'h05, 16'h0000, 8'h03, 4'b0101, 10, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 4'b0000, 18, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'h0080, 8'hFF, 16'hFF80, 8'h00, 4'b1010, 10, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 16'h0064, 8'hF9, 16'hFFF2, 8'h02, 4'b1001, 18, 1'b0};
`ifdef JTKCPU_DIV0_TRAP_EN
    vecs[9] = '{1'b0, 1'b1, 16'h1234, 8'h00, 16'h1234, 8'h00, 4'b0010, 1,  1'b1};
`else
    vecs[9] = '{1'b0, 1'b1, 16'h1234, 8'h00, 16'hFFFF, 8'h34, 4'b1011, 18, 1'b0};
`endif

    rst = 1'b1; cen = 1'b1; req = 1'b0; sign = 1'b0; len = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_ctrl", 32'({div_start, busy, done, div0}), 32'd0);
    check("rst_results", 32'({x_out, b_out, flags}), 32'd0);
    check("rst_ops", 32'({div_op0, div_op1}), 32'd0);
    check("rst_mode", 32'({div_len, div_sign}), 32'd0);

    // Directed vectors
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Done frozen by cen=0, req during DONE ignored, req in IDLE accepted
    @(negedge clk);
    sign = 1'b0; len = 1'b0; dividend = 16'h0040; divisor = 8'h08; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("hold_reach_done", 32'(done), 32'd1);
    cen = 1'b0;
    req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_done_frozen", 32'({done, busy}), 32'b11);
    check("hold_x_out", 32'(x_out), 32'h0008);
    cen = 1'b1;
    @(posedge clk);
    #1;
    check("req_in_done_ignored", 32'({done, busy}), 32'b00);
    @(posedge clk);
    #1 req = 1'b0;
    check("req_in_idle_accepted", 32'({busy, div_start}), 32'b11);
    wait_idle("hold_drain");

    // Reset while the divider is running
    @(negedge clk);
    sign = 1'b0; len = 1'b1; dividend = 16'hFFFF; divisor = 8'hFF; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_in_wait", 32'({busy, div_busy}), 32'b11);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_ctrl", 32'({div_start, busy, done, div0}), 32'd0);
    check("midrst_results", 32'({x_out, b_out, flags}), 32'd0);
    check("midrst_ops", 32'({div_op0, div_op1, div_len, div_sign}), 32'd0);
    run_vec(vecs[0], 100);

    // Back-to-back with req held high and random cen gaps
    @(negedge clk);
    sign = 1'b0; len = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    req = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1 cen = ($urandom_range(0, 3) != 0);
    end
    req = 1'b0;
    cen = 1'b1;
    wait_idle("gated_drain");
    @(negedge clk);
    mon_en = 1'b0;
    check("gated_runs_min", 32'(runs >= 3), 32'd1);
    check("gated_done_per_run", 32'(dones), 32'(runs));
    check("gated_start_per_run", 32'(starts), 32'(runs));
    check("gated_start_gap", 32'(gap_bad), 32'd0);
    check("gated_results", 32'(bad_res), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
